// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, iterative-unit FSM states
// and op classification.
package alu_pkg;

  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NE   = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_LT   = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_GE   = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'd10;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'd11;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 5'd12;
  localparam logic [ALU_OP_W-1:0] ALU_MULH = 5'd13;
  localparam logic [ALU_OP_W-1:0] ALU_DIV  = 5'd14;
  localparam logic [ALU_OP_W-1:0] ALU_REM  = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } alu_state_e;

  function automatic logic is_multicycle(input logic [ALU_OP_W-1:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REM);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply / restoring divide on operand magnitudes, one bit per cycle,
// with the sign correction applied in the final cycle.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                unsigned_flag,
  output logic                done,
  output logic [WIDTH-1:0]    result
);

  logic [CNT_W-1:0]    cnt_r;
  logic [2*WIDTH-1:0]  prod_r;
  logic [WIDTH-1:0]    opnd_r;
  logic                neg_r;
  logic [ALU_OP_W-1:0] op_r;

  logic                a_neg_s, b_neg_s, start_mul_s, start_neg_s;
  logic [WIDTH-1:0]    a_mag_s, b_mag_s;
  logic                op_mul_s, div_ok_s;
  logic [WIDTH:0]      sum_s, shifted_s, diff_s;
  logic [2*WIDTH-1:0]  step_s, prod_fix_s;
  logic [WIDTH-1:0]    quo_fix_s, rem_fix_s;

  // Operand magnitudes and result-sign decision captured on start
  always_comb begin
    a_neg_s     = !unsigned_flag && a[WIDTH-1];
    b_neg_s     = !unsigned_flag && b[WIDTH-1];
    a_mag_s     = a_neg_s ? -a : a;
    b_mag_s     = b_neg_s ? -b : b;
    start_mul_s = (op == ALU_MUL) || (op == ALU_MULH);
    start_neg_s = 1'b0;
    case (op)
      ALU_MUL, ALU_MULH: start_neg_s = a_neg_s ^ b_neg_s;
      // A zero divisor keeps the all-ones quotient regardless of sign
      ALU_DIV:           start_neg_s = (a_neg_s ^ b_neg_s) && (|b);
      ALU_REM:           start_neg_s = a_neg_s;
      default:           start_neg_s = 1'b0;
    endcase
  end

  // One shift-add or restoring-subtract step; upper half accumulates, lower half shifts
  always_comb begin
    op_mul_s  = (op_r == ALU_MUL) || (op_r == ALU_MULH);
    sum_s     = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, (prod_r[0] ? opnd_r : {WIDTH{1'b0}})};
    shifted_s = prod_r[2*WIDTH-1:WIDTH-1];
    diff_s    = shifted_s - {1'b0, opnd_r};
    div_ok_s  = !diff_s[WIDTH];
    if (op_mul_s) begin
      step_s = {sum_s, prod_r[WIDTH-1:1]};
    end else begin
      step_s = {(div_ok_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0]), prod_r[WIDTH-2:0], div_ok_s};
    end
  end

  // The last bit is produced in the FIX cycle, so the result is formed from step_s
  always_comb begin
    prod_fix_s = neg_r ? -step_s : step_s;
    quo_fix_s  = neg_r ? -step_s[WIDTH-1:0] : step_s[WIDTH-1:0];
    rem_fix_s  = neg_r ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
    case (op_r)
      ALU_MUL:  result = prod_fix_s[WIDTH-1:0];
      ALU_MULH: result = prod_fix_s[2*WIDTH-1:WIDTH];
      ALU_DIV:  result = quo_fix_s;
      ALU_REM:  result = rem_fix_s;
      default:  result = {WIDTH{1'b0}};
    endcase
  end

  // Counter reaching 2 means the next cycle (counter 1) is the final one
  assign done = (cnt_r == CNT_W'(2'd2));

  // Operand latch on start, then one iteration per cycle while the counter runs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      prod_r <= {(2*WIDTH){1'b0}};
      opnd_r <= {WIDTH{1'b0}};
      neg_r  <= 1'b0;
      op_r   <= {ALU_OP_W{1'b0}};
    end else if (start) begin
      cnt_r  <= CNT_W'(WIDTH);
      opnd_r <= start_mul_s ? a_mag_s : b_mag_s;
      prod_r <= {{WIDTH{1'b0}}, (start_mul_s ? b_mag_s : a_mag_s)};
      neg_r  <= start_neg_s;
      op_r   <= op;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      prod_r <= step_s;
      cnt_r  <= cnt_r - CNT_W'(1'b1);
    end else begin
      cnt_r  <= cnt_r;
      prod_r <= prod_r;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake; single-cycle ops complete in one
// cycle, multiply/divide run through the iterative unit.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                unsigned_flag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic                unknown_op
);

  alu_state_e       state_r, state_nxt_s;
  logic             out_valid_r, zero_r, unknown_op_r;
  logic [WIDTH-1:0] result_r;
  logic             accept_s, start_md_s, md_done_s, lt_s, sc_unknown_s;
  logic [WIDTH-1:0] md_result_s, sc_result_s;
  logic [SH_W-1:0]  sh_s;

  assign in_ready   = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready;
  assign start_md_s = accept_s && is_multicycle(alu_op);
  assign out_valid  = out_valid_r;
  assign result     = result_r;
  assign zero       = zero_r;
  assign unknown_op = unknown_op_r;

  seq_alu_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk           (clk),
    .reset         (reset),
    .start         (start_md_s),
    .op            (alu_op),
    .a             (a),
    .b             (b),
    .unsigned_flag (unsigned_flag),
    .done          (md_done_s),
    .result        (md_result_s)
  );

  // Single-cycle operations
  always_comb begin
    sc_result_s  = {WIDTH{1'b0}};
    sc_unknown_s = 1'b0;
    sh_s         = b[SH_W-1:0];
    lt_s         = unsigned_flag ? (a < b) : ($signed(a) < $signed(b));
    case (alu_op)
      ALU_AND: sc_result_s = a & b;
      ALU_OR:  sc_result_s = a | b;
      ALU_ADD: sc_result_s = a + b;
      ALU_SUB: sc_result_s = a - b;
      ALU_EQ:  sc_result_s = {{(WIDTH-1){1'b0}}, (a == b)};
      ALU_NE:  sc_result_s = {{(WIDTH-1){1'b0}}, (a != b)};
      ALU_LT:  sc_result_s = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_GE:  sc_result_s = {{(WIDTH-1){1'b0}}, !lt_s};
      ALU_XOR: sc_result_s = a ^ b;
      ALU_SLL: sc_result_s = a << sh_s;
      ALU_SRL: sc_result_s = a >> sh_s;
      ALU_SRA: begin
        if (unsigned_flag) begin
          sc_result_s = a >> sh_s;
        end else begin
          sc_result_s = $unsigned($signed(a) >>> sh_s);
        end
      end
      ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: sc_result_s = {WIDTH{1'b0}};
      default: sc_unknown_s = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_md_s) begin
          state_nxt_s = ((alu_op == ALU_MUL) || (alu_op == ALU_MULH)) ? MUL : DIV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (md_done_s) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = state_r;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output register: loaded from FIX or a single-cycle accept, held under back-pressure
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      result_r     <= {WIDTH{1'b0}};
      zero_r       <= 1'b0;
      unknown_op_r <= 1'b0;
    end else if (state_r == FIX) begin
      out_valid_r  <= 1'b1;
      result_r     <= md_result_s;
      zero_r       <= (md_result_s == {WIDTH{1'b0}});
      unknown_op_r <= 1'b0;
    end else if (accept_s && !is_multicycle(alu_op)) begin
      out_valid_r  <= 1'b1;
      result_r     <= sc_result_s;
      zero_r       <= (sc_result_s == {WIDTH{1'b0}});
      unknown_op_r <= sc_unknown_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   alu_op = 5'd0;
  logic [W-1:0] a = 32'd0;
  logic [W-1:0] b = 32'd0;
  logic         unsigned_flag = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         unknown_op;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b), .unsigned_flag(unsigned_flag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .unknown_op(unknown_op)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         unk;
    time          acc_t;
    int           lat;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_bp = 1'b0;
  int   last_guard = 0;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Reference model: {unknown, result}
  function automatic logic [W:0] model(logic [4:0] op, logic [W-1:0] x, logic [W-1:0] y, logic uf);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    logic [63:0]     p;
    logic [W-1:0]    r = 32'd0;
    int              sh = int'(y[4:0]);
    case (op)
      ALU_AND:  r = x & y;
      ALU_OR:   r = x | y;
      ALU_ADD:  r = x + y;
      ALU_SUB:  r = x - y;
      ALU_EQ:   r = {31'd0, x == y};
      ALU_NE:   r = {31'd0, x != y};
      ALU_LT:   r = {31'd0, uf ? (ux < uy) : (sx < sy)};
      ALU_GE:   r = {31'd0, uf ? (ux >= uy) : (sx >= sy)};
      ALU_XOR:  r = x ^ y;
      ALU_SLL:  r = x << sh;
      ALU_SRL:  r = x >> sh;
      ALU_SRA:  r = uf ? (x >> sh) : 32'(sx >>> sh);
      ALU_MUL, ALU_MULH: begin
        p = uf ? (ux * uy) : 64'(sx * sy);
        r = (op == ALU_MUL) ? p[31:0] : p[63:32];
      end
      ALU_DIV:  r = (y == 32'd0) ? 32'hFFFFFFFF : (uf ? 32'(ux / uy) : 32'(sx / sy));
      ALU_REM:  r = (y == 32'd0) ? x : (uf ? 32'(ux % uy) : 32'(sx % sy));
      default:  return {1'b1, 32'd0};
    endcase
    return {1'b0, r};
  endfunction

  // Called one time unit after a rising edge; returns in the same phase
  task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic uf, input bit use_exp, input logic [W-1:0] exp_res,
                       input string name);
    exp_t       e;
    logic [W:0] m;
    bit         acc = 1'b0;
    int         guard = 0;
    alu_op = op; a = x; b = y; unsigned_flag = uf; in_valid = 1'b1;
    while (!acc && guard < 400) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        m       = model(op, x, y, uf);
        e.res   = use_exp ? exp_res : m[W-1:0];
        e.unk   = m[W];
        e.acc_t = $time;
        e.lat   = is_multicycle(op) ? (W + 1) : 1;
        e.name  = name;
        exp_q.push_back(e);
      end
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL %s: not accepted within 400 cycles", name);
    end
    last_guard = guard;
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 5'($urandom);
    unsigned_flag = 1'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: latency on first sight, stability while held, value on consumption
  bit           fresh = 1'b1;
  logic [W-1:0] held_res;
  logic         held_zero, held_unk;
  exp_t         me;
  int           mlat;
  always @(negedge clk) begin
    if (reset || !out_valid) begin
      fresh = 1'b1;
    end else begin
      if (fresh) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got result %h, expected no output", result);
        end else begin
          me   = exp_q[0];
          mlat = int'(($time - me.acc_t - 5) / 10) + 1;
          chk({me.name, "_latency"}, 32'(mlat), 32'(me.lat));
        end
      end else begin
        chk("hold_result", result, held_res);
        chk("hold_zero", 32'(zero), 32'(held_zero));
        chk("hold_unknown", 32'(unknown_op), 32'(held_unk));
      end
      if (!out_ready) chk("bp_in_ready", 32'(in_ready), 32'd0);
      if (out_ready && exp_q.size() != 0) begin
        me = exp_q.pop_front();
        chk(me.name, result, me.res);
        chk({me.name, "_zero"}, 32'(zero), 32'(me.res == 32'd0));
        chk({me.name, "_unknown"}, 32'(unknown_op), 32'(me.unk));
      end
      fresh     = out_ready;
      held_res  = result;
      held_zero = zero;
      held_unk  = unknown_op;
    end
  end

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    chk("reset_unknown", 32'(unknown_op), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    issue(ALU_ADD, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 32'h80000000, "add_ovf");
    issue(ALU_SUB, 32'd5, 32'd5, 1'b0, 1'b1, 32'd0, "sub_zero");
    issue(ALU_LT, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'd1, "lt_signed");
    issue(ALU_LT, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 32'd0, "lt_unsigned");
    issue(ALU_SRA, 32'h80000000, 32'd4, 1'b0, 1'b1, 32'hF8000000, "sra");
    issue(ALU_SRL, 32'h80000000, 32'd4, 1'b0, 1'b1, 32'h08000000, "srl");
    issue(ALU_SLL, 32'h12345678, 32'h00000020, 1'b0, 1'b1, 32'h12345678, "sll_shamt0");
    drain();

    issue(ALU_MUL, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b1, 32'hFFFFFFEB, "mul_signed");
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
      chk("mul_busy_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    issue(ALU_MULH, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b1, 32'd1, "mulh_unsigned");
    issue(ALU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 32'hFFFFFFFD, "div_signed");
    issue(ALU_REM, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 32'hFFFFFFFF, "rem_signed");
    issue(ALU_DIV, 32'hFFFFFF00, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF, "div_by_zero");
    issue(ALU_REM, 32'hFFFFFF00, 32'd0, 1'b0, 1'b1, 32'hFFFFFF00, "rem_by_zero");
    issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, "div_overflow");
    issue(ALU_REM, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0, "rem_overflow");
    drain();

    out_ready = 1'b0;
    issue(ALU_ADD, 32'd1, 32'd2, 1'b0, 1'b1, 32'd3, "bp_add");
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    issue(ALU_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 1'b0, 1'b1, 32'h0F0FF0F0, "b2b_xor");
    chk("b2b_accept_cycles", 32'(last_guard), 32'd1);
    drain();

    issue(ALU_DIV, 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, "div_aborted");
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    issue(ALU_ADD, 32'd2, 32'd3, 1'b0, 1'b1, 32'd5, "add_after_reset");
    issue(5'd20, 32'd9, 32'd9, 1'b0, 1'b1, 32'd0, "unknown_op20");
    drain();

    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int          r = $urandom_range(0, 19);
      logic [4:0]  op = (r < 16) ? 5'(r) : 5'($urandom_range(16, 31));
      issue(op, rnd_opnd(), rnd_opnd(), 1'($urandom), 1'b0, 32'd0, "random_op");
    end
    rnd_bp = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
